f2h_sdram_rd_master: RTL and testbench
======================================

F2H_SDRAM_RD_MASTER -- requirements
Module: f2h_sdram_rd_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, read-data buffer depth in 64-bit words; power of 2, at least 4.
REQ-002 Parameter MAX_PEND, default 16, maximum outstanding read commands; must not exceed FIFO_DEPTH.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; shared by the block and the f2h_sdram0 port.
- reset, in, 1: synchronous, active-high.
- ctrl_start, in, 1: one-cycle start pulse.
- ctrl_base_addr, in, 26: first SDRAM word address (64-bit words).
- ctrl_len, in, 26: number of words to read.
- ctrl_busy, out, 1: transfer in progress.
- ctrl_done, out, 1: sticky completion flag.
- ctrl_err, out, 1: sticky protocol error.
- avm_address, out, 26: read command address.
- avm_read, out, 1: read command request.
- avm_byteenable, out, 8: byte enables.
- avm_burstcount, out, 1: burst length.
- avm_readdata, in, 64: read data.
- avm_readdatavalid, in, 1: read data valid.
- avm_waitrequest, in, 1: command stall.
- st_data, out, 64: output stream data.
- st_valid, out, 1: output stream valid.
- st_ready, in, 1: output stream ready.
REQ-004 Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.

Function
REQ-005 The block shall act as the Avalon-MM read master driving the f2h_sdram0_data slave; avm_burstcount shall be 1 and avm_byteenable shall be 8'hFF at all times.
REQ-006 The FSM shall have three states: IDLE, ISSUE and FINISH.
- IDLE to ISSUE: on ctrl_start with ctrl_len not 0.
- IDLE to IDLE: on ctrl_start with ctrl_len equal to 0; ctrl_done shall set on the next cycle.
REQ-007 On an accepted start, the block shall latch base_addr and len, clear ctrl_done and ctrl_err, and set ctrl_busy on the next cycle.
REQ-008 ctrl_start shall be ignored while ctrl_busy is 1.
REQ-009 A read command is accepted on any cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 While avm_waitrequest=1, avm_read and avm_address shall hold stable.
REQ-011 The address of command k (0-based) shall be base_addr+k, modulo 2^26.
- The address wraps past 26'h3FFFFFF to 0.
REQ-012 avm_read shall assert in ISSUE only when the following credit check passes: (pending + fifo_count) < FIFO_DEPTH and pending < MAX_PEND, where pending is the count of accepted commands whose data has not yet returned.
REQ-013 pending shall increment on command accept and decrement on avm_readdatavalid; on a simultaneous accept and readdatavalid, pending shall be unchanged.
REQ-014 Every avm_readdatavalid beat shall be written into the FIFO in arrival order.
- The credit rule guarantees the FIFO never overflows.
REQ-015 If avm_readdatavalid arrives while pending=0, the beat shall be dropped and ctrl_err shall set.
REQ-016 The FIFO is show-ahead:
- st_valid=1 whenever the FIFO is not empty, and st_data is the head entry.
- A pop occurs on st_valid and st_ready.
- A simultaneous push and pop leaves fifo_count unchanged.
REQ-017 ISSUE to FINISH: on the cycle in which the len-th command is accepted.
REQ-018 FINISH to IDLE: when pending=0 and the FIFO is empty. ctrl_busy shall clear and ctrl_done shall set in the same cycle.
REQ-019 No word shall be emitted before its command's data returns.
- Minimum latency from command accept to st_valid is 1 cycle after readdatavalid.

Reset
REQ-020 On reset the block shall:
- go to IDLE;
- clear pending, fifo_count and the FIFO pointers;
- drive avm_read=0, st_valid=0, ctrl_busy=0, ctrl_done=0, ctrl_err=0, avm_address=0 and st_data=0.
REQ-021 A reset in the middle of a transfer shall abort it immediately. Read data returning after reset shall not be counted as an error.
- To support this, a 1-cycle quiet window is allowed.
- The integrator shall hold reset until the SDRAM port is idle.

Verification
REQ-022 Basic transfer: base=0x100, len=4, waitrequest=0, 2-cycle read latency, st_ready=1.
- Addresses 0x100 to 0x103 issued on 4 consecutive cycles.
- st_data matches memory in order.
- ctrl_done=1 one cycle after the last pop.
REQ-023 Backpressure: len=40, st_ready=0 for 100 cycles.
- Exactly FIFO_DEPTH commands are issued, then avm_read=0.
- After st_ready=1, all 40 words arrive in order with no loss or duplication.
REQ-024 Waitrequest: waitrequest=1 for 5 cycles on the 2nd command.
- avm_address holds at base+1 for those cycles.
- Total commands issued = len.
REQ-025 Wrap and zero length:
- base=0x3FFFFFE, len=3 gives addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000.
- len=0 gives no avm_read and ctrl_done=1 the next cycle.
REQ-026 Error and restart:
- A readdatavalid pulse in IDLE sets ctrl_err=1 and leaves the FIFO empty.
- ctrl_start while busy is ignored.
- Reset mid-transfer (after 3 of 10 words) returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/f2h_sdram_rd_master.sv
// Avalon-MM read master for the f2h_sdram0 port: issues single-word reads
// under a credit limit and streams the returned data out through a show-ahead FIFO.
module f2h_sdram_rd_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PEND   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic [25:0] ctrl_base_addr,
    input  logic [25:0] ctrl_len,
    output logic        ctrl_busy,
    output logic        ctrl_done,
    output logic        ctrl_err,
    output logic [25:0] avm_address,
    output logic        avm_read,
    output logic [7:0]  avm_byteenable,
    output logic        avm_burstcount,
    input  logic [63:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest,
    output logic [63:0] st_data,
    output logic        st_valid,
    input  logic        st_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

    state_t        state;
    logic [25:0]   remaining;
    logic [CW-1:0] pending;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic          quiet;

    logic          cmd_accept;
    logic          push;
    logic          pop;
    logic          stray;
    logic          credit_ok;
    logic [CW-1:0] pending_next;
    logic [CW-1:0] fifo_count_next;
    logic [25:0]   remaining_next;

    assign avm_burstcount = 1'b1;
    assign avm_byteenable = 8'hFF;

    assign st_valid = (fifo_count != '0);
    assign st_data  = st_valid ? fifo_mem[rd_ptr] : 64'd0;

    // Beats with no outstanding command are dropped; the cycle right after reset
    // is a quiet window so late data from an aborted transfer is not flagged.
    assign cmd_accept = avm_read & ~avm_waitrequest;
    assign push       = avm_readdatavalid & (pending != '0);
    assign stray      = avm_readdatavalid & (pending == '0) & ~quiet;
    assign pop        = st_valid & st_ready;

    assign pending_next    = pending + CW'(cmd_accept) - CW'(push);
    assign fifo_count_next = fifo_count + CW'(push) - CW'(pop);
    assign remaining_next  = remaining - 26'(cmd_accept);

    // Credit is judged on next-cycle occupancy so a newly asserted read always has a free FIFO slot.
    assign credit_ok = (({1'b0, pending_next} + {1'b0, fifo_count_next}) < (CW+1)'(FIFO_DEPTH))
                       && (pending_next < CW'(MAX_PEND));

    always_ff @(posedge clk) begin
        if (push && !reset)
            fifo_mem[wr_ptr] <= avm_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            pending     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            ctrl_busy   <= 1'b0;
            ctrl_done   <= 1'b0;
            ctrl_err    <= 1'b0;
            quiet       <= 1'b1;
        end else begin
            quiet      <= 1'b0;
            pending    <= pending_next;
            fifo_count <= fifo_count_next;
            remaining  <= remaining_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (cmd_accept)
                avm_address <= avm_address + 26'd1;

            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        ctrl_err <= 1'b0;
                        if (ctrl_len == '0) begin
                            ctrl_done <= 1'b1;
                        end else begin
                            ctrl_done   <= 1'b0;
                            ctrl_busy   <= 1'b1;
                            avm_address <= ctrl_base_addr;
                            remaining   <= ctrl_len;
                            avm_read    <= credit_ok;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // A stalled command holds; otherwise re-evaluate credit each cycle.
                    if (avm_read && avm_waitrequest) begin
                        avm_read <= 1'b1;
                    end else if (remaining_next == '0) begin
                        avm_read <= 1'b0;
                        state    <= FINISH;
                    end else begin
                        avm_read <= credit_ok;
                    end
                end
                FINISH: begin
                    if (pending_next == '0 && fifo_count_next == '0) begin
                        ctrl_busy <= 1'b0;
                        ctrl_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stray)
                ctrl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_f2h_sdram_rd_master.sv
// Directed bench for f2h_sdram_rd_master: a 2-cycle-latency SDRAM model,
// a stream consumer and hand-computed expected addresses and data.
module tb_f2h_sdram_rd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_start;
    logic [25:0] ctrl_base_addr;
    logic [25:0] ctrl_len;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        ctrl_err;
    logic [25:0] avm_address;
    logic        avm_read;
    logic [7:0]  avm_byteenable;
    logic        avm_burstcount;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;
    logic [63:0] st_data;
    logic        st_valid;
    logic        st_ready;

    always #5 clk = ~clk;

    f2h_sdram_rd_master dut (
        .clk               (clk),
        .reset             (reset),
        .ctrl_start        (ctrl_start),
        .ctrl_base_addr    (ctrl_base_addr),
        .ctrl_len          (ctrl_len),
        .ctrl_busy         (ctrl_busy),
        .ctrl_done         (ctrl_done),
        .ctrl_err          (ctrl_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pop_idx = 0;
    int          last_pop_cyc = -1;
    int          done_cyc = -1;
    int          stall_left = 0;
    bit          inject = 1'b0;
    logic        pipe_v = 1'b0;
    logic [63:0] pipe_d = 64'd0;
    logic [25:0] exp_base = 26'd0;
    logic [25:0] issue_q[$];
    int          acc_cyc_q[$];
    logic [25:0] stall_addr_q[$];

    function automatic logic [63:0] modelWord(input logic [25:0] a);
        return {6'h15, a, 6'h2A, a ^ 26'h1555555};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: records what the coming edge does, then plays SDRAM slave at the negedge.
    task automatic stepCycle();
        logic        pop_now;
        logic        acc_now;
        logic [63:0] pop_word;
        logic [25:0] acc_addr;
        pop_now  = st_valid && st_ready;
        pop_word = st_data;
        acc_now  = avm_read && !avm_waitrequest;
        acc_addr = avm_address;
        @(negedge clk);
        cyc++;
        if (pop_now === 1'b1) begin
            checkOutput($sformatf("pop_data%0d", pop_idx), pop_word, modelWord(exp_base + 26'(pop_idx)));
            pop_idx++;
            last_pop_cyc = cyc;
        end
        if (acc_now === 1'b1) begin
            issue_q.push_back(acc_addr);
            acc_cyc_q.push_back(cyc);
        end
        avm_readdatavalid = pipe_v;
        avm_readdata      = pipe_d;
        if (inject) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
            inject            = 1'b0;
        end
        pipe_v = (acc_now === 1'b1);
        pipe_d = modelWord(acc_addr);
        if (stall_left > 0 && avm_read && issue_q.size() == 1) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            stall_addr_q.push_back(avm_address);
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (ctrl_done === 1'b1 && done_cyc < 0)
            done_cyc = cyc;
    endtask

    task automatic applyStimulus(input logic [25:0] base, input logic [25:0] len);
        ctrl_start     = 1'b1;
        ctrl_base_addr = base;
        ctrl_len       = len;
        exp_base       = base;
        pop_idx        = 0;
        done_cyc       = -1;
        last_pop_cyc   = -1;
        issue_q.delete();
        acc_cyc_q.delete();
        stepCycle();
        ctrl_start = 1'b0;
    endtask

    task automatic waitDone(input int bound, input string tag);
        int n = 0;
        while (!(ctrl_done && !ctrl_busy) && n < bound) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_done"}, 64'(ctrl_done), 64'd1);
    endtask

    function automatic int countBadAddr(input logic [25:0] base);
        int bad = 0;
        foreach (issue_q[k])
            if (issue_q[k] !== base + 26'(k))
                bad++;
        return bad;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_avm_read"}, 64'(avm_read), 64'd0);
        checkOutput({tag, "_st_valid"}, 64'(st_valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(ctrl_done), 64'd0);
        checkOutput({tag, "_err"}, 64'(ctrl_err), 64'd0);
        checkOutput({tag, "_address"}, 64'(avm_address), 64'd0);
        checkOutput({tag, "_st_data"}, st_data, 64'd0);
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        ctrl_start        = 1'b0;
        ctrl_base_addr    = '0;
        ctrl_len          = '0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        st_ready          = 1'b0;

        repeat (3) stepCycle();
        checkResetOutputs("rst");
        reset = 1'b0;
        stepCycle();

        $display("[TB] zero-length start");
        applyStimulus(26'h123, 26'd0);
        checkOutput("zlen_done", 64'(ctrl_done), 64'd1);
        checkOutput("zlen_busy", 64'(ctrl_busy), 64'd0);
        repeat (3) stepCycle();
        checkOutput("zlen_no_read", 64'(issue_q.size()), 64'd0);

        $display("[TB] basic transfer");
        st_ready = 1'b1;
        applyStimulus(26'h100, 26'd4);
        checkOutput("basic_busy", 64'(ctrl_busy), 64'd1);
        checkOutput("basic_done_clr", 64'(ctrl_done), 64'd0);
        checkOutput("byteenable", 64'(avm_byteenable), 64'hFF);
        checkOutput("burstcount", 64'(avm_burstcount), 64'd1);
        waitDone(50, "basic");
        checkOutput("basic_ncmd", 64'(issue_q.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("basic_addr%0d", k), 64'(issue_q[k]), 64'(26'h100 + 26'(k)));
        checkOutput("basic_consecutive", 64'(acc_cyc_q[3] - acc_cyc_q[0]), 64'd3);
        checkOutput("basic_npop", 64'(pop_idx), 64'd4);
        checkOutput("basic_done_timing", 64'(done_cyc), 64'(last_pop_cyc));

        $display("[TB] backpressure");
        st_ready = 1'b0;
        applyStimulus(26'h1000, 26'd40);
        repeat (100) stepCycle();
        checkOutput("bp_ncmd_stalled", 64'(issue_q.size()), 64'd16);
        checkOutput("bp_read_low", 64'(avm_read), 64'd0);
        checkOutput("bp_st_valid", 64'(st_valid), 64'd1);
        st_ready = 1'b1;
        waitDone(400, "bp");
        checkOutput("bp_ncmd", 64'(issue_q.size()), 64'd40);
        checkOutput("bp_addr_order", 64'(countBadAddr(26'h1000)), 64'd0);
        checkOutput("bp_npop", 64'(pop_idx), 64'd40);

        $display("[TB] waitrequest on second command");
        stall_addr_q.delete();
        stall_left = 5;
        applyStimulus(26'h200, 26'd6);
        waitDone(100, "wr");
        checkOutput("wr_stall_cycles", 64'(stall_addr_q.size()), 64'd5);
        n = 0;
        foreach (stall_addr_q[k])
            if (stall_addr_q[k] !== 26'h201)
                n++;
        checkOutput("wr_addr_hold", 64'(n), 64'd0);
        checkOutput("wr_ncmd", 64'(issue_q.size()), 64'd6);
        checkOutput("wr_addr_order", 64'(countBadAddr(26'h200)), 64'd0);
        checkOutput("wr_npop", 64'(pop_idx), 64'd6);

        $display("[TB] address wrap");
        applyStimulus(26'h3FFFFFE, 26'd3);
        waitDone(50, "wrap");
        checkOutput("wrap_addr0", 64'(issue_q[0]), 64'h3FFFFFE);
        checkOutput("wrap_addr1", 64'(issue_q[1]), 64'h3FFFFFF);
        checkOutput("wrap_addr2", 64'(issue_q[2]), 64'h0000000);
        checkOutput("wrap_npop", 64'(pop_idx), 64'd3);

        $display("[TB] stray readdatavalid in idle");
        inject = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("stray_err", 64'(ctrl_err), 64'd1);
        checkOutput("stray_fifo_empty", 64'(st_valid), 64'd0);

        $display("[TB] start while busy");
        applyStimulus(26'h400, 26'd10);
        checkOutput("restart_err_clr", 64'(ctrl_err), 64'd0);
        repeat (2) stepCycle();
        ctrl_start     = 1'b1;
        ctrl_base_addr = 26'h500;
        ctrl_len       = 26'd2;
        stepCycle();
        ctrl_start = 1'b0;
        waitDone(200, "busy_start");
        checkOutput("busy_ncmd", 64'(issue_q.size()), 64'd10);
        checkOutput("busy_addr_order", 64'(countBadAddr(26'h400)), 64'd0);
        checkOutput("busy_npop", 64'(pop_idx), 64'd10);

        $display("[TB] reset mid-transfer");
        applyStimulus(26'h600, 26'd10);
        n = 0;
        while (pop_idx < 3 && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("midrst_reached3", 64'(pop_idx >= 3), 64'd1);
        reset = 1'b1;
        stepCycle();
        checkResetOutputs("midrst");
        repeat (3) stepCycle();
        reset = 1'b0;
        repeat (3) stepCycle();
        checkOutput("midrst_err_quiet", 64'(ctrl_err), 64'd0);
        checkOutput("midrst_idle_read", 64'(avm_read), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
